// File: rtl/alu_issue_stage.sv
// Decode/issue stage: RV32 R-type and OP-IMM decode into a 2-entry skid buffer toward the ALU.
// Optional macro ALU_ISSUE_STATS_EN adds issued_count and illegal_count outputs.
module alu_issue_stage #(
   parameter int WIDTH   = 32,
   parameter int REGADDR = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [31:0]        instr,
   output logic [REGADDR-1:0] rs1_addr,
   output logic [REGADDR-1:0] rs2_addr,
   input  logic [WIDTH-1:0]   rs1_data,
   input  logic [WIDTH-1:0]   rs2_data,
   input  logic               flush,
   output logic               alu_valid,
   input  logic               alu_ready,
   output logic [WIDTH-1:0]   op1,
   output logic [WIDTH-1:0]   op2,
   output logic [6:0]         opcode,
   output logic [2:0]         funct3,
   output logic [6:0]         funct7,
   output logic [REGADDR-1:0] rd,
   output logic               illegal
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [31:0]        issued_count,
   output logic [31:0]        illegal_count
`endif
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid never depends on ready, and instr_ready depends on buffer state only.

   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_IMM = 7'b0010011;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   typedef struct packed {
      logic [WIDTH-1:0]   op1;
      logic [WIDTH-1:0]   op2;
      logic [6:0]         opcode;
      logic [2:0]         funct3;
      logic [6:0]         funct7;
      logic [REGADDR-1:0] rd;
   } entry_t;

   state_t state, state_n;
   entry_t out_q, skid_q, dec;
   logic   dec_legal;
   logic   accept, push, pop;
   logic   load_out, load_skid, skid_to_out;
   logic [6:0] ins_f7;
   logic [2:0] ins_f3;

   assign ins_f7   = instr[31:25];
   assign ins_f3   = instr[14:12];
   assign rs1_addr = REGADDR'(instr[19:15]);
   assign rs2_addr = REGADDR'(instr[24:20]);

   always_comb begin
      dec_legal   = 1'b0;
      dec.op1     = rs1_data;
      dec.op2     = rs2_data;
      dec.opcode  = instr[6:0];
      dec.funct3  = ins_f3;
      dec.funct7  = ins_f7;
      dec.rd      = REGADDR'(instr[11:7]);
      case (instr[6:0])
         OPC_R: begin
            case (ins_f3)
               3'b000:          dec_legal = (ins_f7 == 7'b0000000) || (ins_f7 == 7'b0100000) ||
                                            (ins_f7 == 7'b0000001);
               3'b100, 3'b110:  dec_legal = (ins_f7 == 7'b0000000) || (ins_f7 == 7'b0000001);
               3'b101:          dec_legal = (ins_f7 == 7'b0000000) || (ins_f7 == 7'b0100000);
               default:         dec_legal = (ins_f7 == 7'b0000000);
            endcase
         end
         OPC_IMM: begin
            if (ins_f3 == 3'b001 || ins_f3 == 3'b101) begin
               // Shifts carry a 5-bit shamt; funct7 selects logical/arithmetic.
               dec.op2   = WIDTH'(instr[24:20]);
               dec_legal = (ins_f7 == 7'b0000000) ||
                           (ins_f7 == 7'b0100000 && ins_f3 == 3'b101);
            end else begin
               dec.op2    = {{(WIDTH-12){instr[31]}}, instr[31:20]};
               dec.funct7 = 7'b0000000;
               dec_legal  = 1'b1;
            end
         end
         default: dec_legal = 1'b0;
      endcase
   end

   assign instr_ready = (state != FULL);
   assign alu_valid   = (state != EMPTY);
   assign accept      = instr_valid && instr_ready;
   assign push        = accept && dec_legal;
   assign pop         = alu_valid && alu_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_n;
   end

   always_comb begin
      state_n     = state;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      if (flush) begin
         state_n = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  state_n  = ONE;
                  load_out = 1'b1;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  state_n   = FULL;
                  load_skid = 1'b1;
               end else if (push && pop) begin
                  load_out = 1'b1;
               end else if (pop) begin
                  state_n = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  state_n     = ONE;
                  skid_to_out = 1'b1;
               end
            end
            default: state_n = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out)         out_q  <= dec;
         else if (skid_to_out) out_q  <= skid_q;
         if (load_skid)        skid_q <= dec;
      end
   end

   // Illegal encodings are consumed here and never occupy a buffer entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        illegal <= 1'b0;
      else if (flush) illegal <= 1'b0;
      else            illegal <= accept && !dec_legal;
   end

   assign op1    = out_q.op1;
   assign op2    = out_q.op2;
   assign opcode = out_q.opcode;
   assign funct3 = out_q.funct3;
   assign funct7 = out_q.funct7;
   assign rd     = out_q.rd;

`ifdef ALU_ISSUE_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issued_count  <= '0;
         illegal_count <= '0;
      end else begin
         if (pop)     issued_count  <= issued_count + 32'd1;
         if (illegal) illegal_count <= illegal_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: queue-based issue model, per-cycle compare, directed vectors.
module tb_alu_issue_stage;

   localparam int EW = 86;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] instr = '0;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic        flush = 1'b0;
   logic        alu_valid;
   logic        alu_ready = 1'b1;
   logic [31:0] op1, op2;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic        illegal;
`ifdef ALU_ISSUE_STATS_EN
   logic [31:0] issued_count, illegal_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [EW-1:0] exp_q[$];
   logic          exp_ill;
   int            m_issued, m_illcnt;
   logic [EW-1:0] m_e;
   bit            m_lg, m_rdy;

   alu_issue_stage #(.WIDTH(32), .REGADDR(5)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .flush(flush),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .op1(op1), .op2(op2), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
      .illegal(illegal)
`ifdef ALU_ISSUE_STATS_EN
      , .issued_count(issued_count), .illegal_count(illegal_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference decode straight from the ISA rules: returns legality and the packed entry.
   function automatic bit m_decode(input logic [31:0] w, input logic [31:0] a,
                                   input logic [31:0] b, output logic [EW-1:0] e);
      logic [6:0]  opc, f7, f7o;
      logic [2:0]  f3;
      logic [31:0] o2;
      bit          lg;
      opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
      o2 = b; f7o = f7; lg = 0;
      if (opc == 7'b0110011) begin
         lg = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
              (f7 == 7'h01 && (f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd6));
      end else if (opc == 7'b0010011) begin
         if (f3 == 3'd1 || f3 == 3'd5) begin
            o2 = {27'd0, w[24:20]};
            lg = (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
         end else begin
            o2  = 32'($signed(w[31:20]));
            f7o = 7'h00;
            lg  = 1;
         end
      end
      e = {a, o2, opc, f3, f7o, w[11:7]};
      return lg;
   endfunction

   // Model: ordered queue of pending issues (head = what the ALU sees), capacity 2.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         exp_ill  = 1'b0;
         m_issued = 0;
         m_illcnt = 0;
      end else begin
         m_rdy = (exp_q.size() < 2);
         if (exp_ill) m_illcnt++;
         if (exp_q.size() > 0 && alu_ready) m_issued++;
         if (flush) begin
            exp_q.delete();
            exp_ill = 1'b0;
         end else begin
            if (exp_q.size() > 0 && alu_ready) void'(exp_q.pop_front());
            exp_ill = 1'b0;
            if (instr_valid && m_rdy) begin
               m_lg = m_decode(instr, rs1_data, rs2_data, m_e);
               if (m_lg) exp_q.push_back(m_e);
               else      exp_ill = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("instr_ready", EW'(instr_ready), EW'(exp_q.size() < 2));
         check("alu_valid", EW'(alu_valid), EW'(exp_q.size() > 0));
         if (exp_q.size() > 0)
            check("fields", {op1, op2, opcode, funct3, funct7, rd}, exp_q[0]);
         check("illegal", EW'(illegal), EW'(exp_ill));
         check("rs1_addr", EW'(rs1_addr), EW'(instr[19:15]));
         check("rs2_addr", EW'(rs2_addr), EW'(instr[24:20]));
`ifdef ALU_ISSUE_STATS_EN
         check("issued_count", EW'(issued_count), EW'(m_issued));
         check("illegal_count", EW'(illegal_count), EW'(m_illcnt));
`endif
      end
   end

   // Present one instruction until accepted; returns 1 ns after the accepting edge.
   task automatic send(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
      bit acc;
      acc = 0;
      instr = w; rs1_data = a; rs2_data = b; instr_valid = 1'b1;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = (exp_q.size() < 2);
         @(posedge clk);
         #1;
      end
      instr_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL send_timeout act=not_accepted exp=accepted instr=%h", w);
      end
   endtask

   logic [31:0] vec_instr [8];
   logic [31:0] r_illegal;

   initial begin
      vec_instr[0] = {7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33};   // SUB
      vec_instr[1] = {7'h01, 5'd2, 5'd1, 3'd0, 5'd6, 7'h33};   // MUL
      vec_instr[2] = {7'h00, 5'd31, 5'd1, 3'd1, 5'd7, 7'h13};  // SLLI 31
      vec_instr[3] = {7'h20, 5'd3, 5'd1, 3'd1, 5'd7, 7'h13};   // SLLI funct7=0100000, illegal
      vec_instr[4] = {12'h800, 5'd1, 3'd2, 5'd8, 7'h13};       // SLTI -2048
      vec_instr[5] = {7'h01, 5'd2, 5'd1, 3'd5, 5'd9, 7'h33};   // funct3 101 funct7 0000001, illegal
      vec_instr[6] = {7'h00, 5'd2, 5'd1, 3'd6, 5'd10, 7'h33};  // OR
      vec_instr[7] = {12'h7FF, 5'd3, 3'd7, 5'd11, 7'h13};      // ANDI 2047

      repeat (2) @(negedge clk);
      check("rst_alu_valid", EW'(alu_valid), EW'(0));
      check("rst_illegal", EW'(illegal), EW'(0));
      check("rst_fields", {op1, op2, opcode, funct3, funct7, rd}, EW'(0));
`ifdef ALU_ISSUE_STATS_EN
      check("rst_counts", EW'({issued_count, illegal_count}), EW'(0));
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      // ADD x3,x1,x2
      send(32'h002081B3, 32'd5, 32'd7);
      check("add_valid", EW'(alu_valid), EW'(1));
      check("add_fields", {op1, op2, opcode, funct3, funct7, rd},
            {32'd5, 32'd7, 7'b0110011, 3'b000, 7'b0000000, 5'd3});
      // ADDI x1,x0,-1
      send(32'hFFF00093, 32'd0, 32'h1234);
      check("addi_fields", {op2, funct3, funct7, rd}, EW'({32'hFFFFFFFF, 3'b000, 7'b0, 5'd1}));
      // SRAI x5,x6,4
      send(32'h40435293, 32'h80000000, 32'h5555);
      check("srai_fields", {op1, op2, funct7, funct3, rd},
            EW'({32'h80000000, 32'd4, 7'b0100000, 3'b101, 5'd5}));
      // LW is consumed as illegal
      send(32'h00002083, 32'd1, 32'd2);
      check("lw_illegal", EW'(illegal), EW'(1));
      check("lw_no_issue", EW'(alu_valid), EW'(0));
      @(posedge clk); #1;
      check("lw_pulse_end", EW'(illegal), EW'(0));
      r_illegal = {7'b0000001, 5'd2, 5'd1, 3'b111, 5'd4, 7'b0110011};
      send(r_illegal, 32'd1, 32'd2);
      check("r111_illegal", EW'(illegal), EW'(1));
      @(posedge clk); #1;
`ifdef ALU_ISSUE_STATS_EN
      check("counts_pin", EW'({issued_count, illegal_count}), EW'({32'd3, 32'd2}));
`endif

      // Backpressure: three back-to-back with the ALU stalled
      alu_ready = 1'b0;
      send(32'h002081B3, 32'd11, 32'd12);
      send(32'h00308233, 32'd21, 32'd22);
      check("full_not_ready", EW'(instr_ready), EW'(0));
      check("full_hold_op1", EW'(op1), EW'(11));
      fork
         send(32'hFFF00093, 32'd31, 32'd32);
         begin
            repeat (3) @(posedge clk);
            #1 alu_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      #1;

      // Directed table with alternating backpressure
      for (int i = 0; i < 8; i++) begin
         alu_ready = i[0];
         send(vec_instr[i], 32'h100 + i, 32'hFFFF0000 + i);
      end
      alu_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Flush while FULL with an instruction offered
      alu_ready = 1'b0;
      send(32'h002081B3, 32'd41, 32'd42);
      send(32'h00308233, 32'd43, 32'd44);
      instr = 32'h40435293; rs1_data = 32'd45; instr_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; instr_valid = 1'b0;
      check("flush_valid", EW'(alu_valid), EW'(0));
      check("flush_ready", EW'(instr_ready), EW'(1));
`ifdef ALU_ISSUE_STATS_EN
      check("flush_issued", EW'(issued_count), EW'(m_issued));
`endif
      alu_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("flush_nothing", EW'(alu_valid), EW'(0));

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
